// File: rtl/sb_cfg_mux.sv
// Switch-box slice: each output track selects one input track via its own config
// register, and can be driven combinationally or through a one-cycle register.
module sb_cfg_mux #(
    parameter int WIDTH    = 16,
    parameter int NUM_IN   = 5,
    parameter int NUM_OUT  = 4,
    parameter int SEL_BITS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       config_en,
    input  logic                       config_read,
    input  logic [31:0]                config_addr,
    input  logic [31:0]                config_data,
    output logic [31:0]                read_data,
    input  logic [NUM_IN*WIDTH-1:0]    in,
    output logic [NUM_OUT*WIDTH-1:0]   out
);

    logic [7:0]          cfg_idx;
    logic [SEL_BITS-1:0] sel_cfg  [NUM_OUT];
    logic                mode_cfg [NUM_OUT];
    logic                en_cfg   [NUM_OUT];
    logic [WIDTH-1:0]    mux_p0   [NUM_OUT];
    logic [WIDTH-1:0]    mux_p1   [NUM_OUT];
    logic [31:0]         rd_word;

    assign cfg_idx = config_addr[31:24];

    function automatic logic [31:0] pack_cfg(input logic [SEL_BITS-1:0] sel,
                                             input logic mode, input logic en);
        logic [31:0] word;
        word               = '0;
        word[SEL_BITS-1:0] = sel;
        word[8]            = mode;
        word[16]           = en;
        return word;
    endfunction

    // Select decode compares against every legal input, so selects past NUM_IN give 0.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            mux_p0[k] = '0;
            if (en_cfg[k]) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (sel_cfg[k] == SEL_BITS'(i)) begin
                        mux_p0[k] = in[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (cfg_idx == 8'(k)) begin
                rd_word = pack_cfg(sel_cfg[k], mode_cfg[k], en_cfg[k]);
            end
        end
    end

    // ---- stage p0 -> p1: config update, readback and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                sel_cfg[k]  <= '0;
                mode_cfg[k] <= 1'b0;
                en_cfg[k]   <= 1'b0;
                mux_p1[k]   <= '0;
            end
            read_data <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                mux_p1[k] <= mux_p0[k];
                if (config_en && cfg_idx == 8'(k)) begin
                    sel_cfg[k]  <= config_data[SEL_BITS-1:0];
                    mode_cfg[k] <= config_data[8];
                    en_cfg[k]   <= config_data[16];
                end
            end
            if (config_read) begin
                read_data <= rd_word;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out[k*WIDTH +: WIDTH] = mode_cfg[k] ? mux_p1[k] : mux_p0[k];
        end
    end

endmodule

// File: tb/tb_sb_cfg_mux.sv
// Randomised self-checking bench for sb_cfg_mux against a word-level reference model.
module tb_sb_cfg_mux;

    localparam int WIDTH    = 16;
    localparam int NUM_IN   = 5;
    localparam int NUM_OUT  = 4;
    localparam int SEL_BITS = 3;
    localparam logic [31:0] MASK = 32'h0001_0100 | ((32'd1 << SEL_BITS) - 32'd1);

    logic                       clk;
    logic                       reset;
    logic                       config_en;
    logic                       config_read;
    logic [31:0]                config_addr;
    logic [31:0]                config_data;
    logic [31:0]                read_data;
    logic [NUM_IN*WIDTH-1:0]    in_bus;
    logic [NUM_OUT*WIDTH-1:0]   out_bus;

    sb_cfg_mux #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SEL_BITS(SEL_BITS)
    ) dut (
        .clk(clk), .reset(reset), .config_en(config_en), .config_read(config_read),
        .config_addr(config_addr), .config_data(config_data), .read_data(read_data),
        .in(in_bus), .out(out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: config words as read back, previous-cycle mux values, readback.
    logic [31:0]      cfg_m  [NUM_OUT];
    logic [WIDTH-1:0] pipe_m [NUM_OUT];
    logic [31:0]      rd_m;

    function automatic logic [WIDTH-1:0] exp_mux(int k);
        int s;
        s = int'(cfg_m[k][SEL_BITS-1:0]);
        if (cfg_m[k][16] && s < NUM_IN) return in_bus[s*WIDTH +: WIDTH];
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_out(int k);
        return cfg_m[k][8] ? pipe_m[k] : exp_mux(k);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NUM_OUT; k++) begin
            cfg_m[k]  = '0;
            pipe_m[k] = '0;
        end
        rd_m = '0;
    endtask

    // Advance one clock edge, updating the model with the strobes currently driven.
    task automatic step();
        logic [WIDTH-1:0] np [NUM_OUT];
        int idx;
        idx = int'(config_addr[31:24]);
        for (int k = 0; k < NUM_OUT; k++) np[k] = exp_mux(k);
        if (config_read) rd_m = (idx < NUM_OUT) ? cfg_m[idx] : 32'd0;
        if (config_en && idx < NUM_OUT) cfg_m[idx] = config_data & MASK;
        for (int k = 0; k < NUM_OUT; k++) pipe_m[k] = np[k];
        @(posedge clk);
        #1;
        config_en   = 1'b0;
        config_read = 1'b0;
    endtask

    task automatic set_track(int i, logic [WIDTH-1:0] v);
        in_bus[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NUM_IN; i++) set_track(i, WIDTH'($urandom));
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        in_bus      = '1;
        config_en   = 1'b1;
        config_read = 1'b1;
        config_addr = 32'h0000_0000;
        config_data = 32'h0001_0103;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_bus !== '0) begin
            failures++; $display("FAIL reset_out_during got=%h want=0", out_bus);
        end
        checks++;
        if (read_data !== 32'd0) begin
            failures++; $display("FAIL reset_rd_during got=%h want=0", read_data);
        end
        config_en   = 1'b0;
        config_read = 1'b0;
        reset       = 1'b0;
        reset_model();
        step();
        checks++;
        if (out_bus !== '0) begin
            failures++; $display("FAIL reset_out_after got=%h want=0", out_bus);
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            config_read = 1'b1;
            config_addr = {8'(k), 24'd0};
            step();
            checks++;
            if (read_data !== 32'd0) begin
                failures++; $display("FAIL reset_readback idx=%0d got=%h want=0", k, read_data);
            end
        end
    endtask

    task automatic test_comb();
        in_bus      = '0;
        config_en   = 1'b1;
        config_addr = {8'd2, 24'd0};
        config_data = 32'h0001_0003;
        step();
        set_track(3, 16'hA5A5);
        #1;
        checks++;
        if (out_bus !== {16'h0, 16'hA5A5, 16'h0, 16'h0}) begin
            failures++; $display("FAIL comb_out2 got=%h want=0000a5a500000000", out_bus);
        end
        set_track(3, 16'h5A5A);
        #1;
        checks++;
        if (out_bus[2*WIDTH +: WIDTH] !== 16'h5A5A) begin
            failures++; $display("FAIL comb_follow got=%h want=5a5a", out_bus[2*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_reg();
        config_en   = 1'b1;
        config_addr = {8'd1, 24'd0};
        config_data = 32'h0001_0104;
        set_track(4, 16'h0000);
        step();
        step();
        set_track(4, 16'h1234);
        #1;
        checks++;
        if (out_bus[WIDTH +: WIDTH] !== 16'h0000) begin
            failures++; $display("FAIL reg_before_edge got=%h want=0000", out_bus[WIDTH +: WIDTH]);
        end
        step();
        checks++;
        if (out_bus[WIDTH +: WIDTH] !== 16'h1234) begin
            failures++; $display("FAIL reg_after_edge got=%h want=1234", out_bus[WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_oob();
        logic [31:0] snap [NUM_OUT];
        randomize_inputs();
        config_en   = 1'b1;
        config_addr = {8'd0, 24'd0};
        config_data = 32'h0001_0007;
        step();
        checks++;
        if (out_bus[0 +: WIDTH] !== 16'h0000) begin
            failures++; $display("FAIL oob_sel got=%h want=0000", out_bus[0 +: WIDTH]);
        end
        for (int k = 0; k < NUM_OUT; k++) snap[k] = cfg_m[k];
        config_en   = 1'b1;
        config_addr = {8'd5, 24'd0};
        config_data = $urandom | 32'h0001_0000;
        step();
        for (int k = 0; k < NUM_OUT; k++) begin
            config_read = 1'b1;
            config_addr = {8'(k), 24'd0};
            step();
            checks++;
            if (read_data !== snap[k]) begin
                failures++; $display("FAIL oob_write_idx%0d got=%h want=%h", k, read_data, snap[k]);
            end
        end
        config_read = 1'b1;
        config_addr = {8'd2, 24'd0};
        step();
        config_read = 1'b1;
        config_addr = {8'd5, 24'd0};
        step();
        checks++;
        if (read_data !== 32'd0) begin
            failures++; $display("FAIL oob_read got=%h want=0", read_data);
        end
    endtask

    task automatic test_same_edge();
        config_en   = 1'b1;
        config_read = 1'b1;
        config_addr = {8'd2, 24'd0};
        config_data = 32'h0001_0001;
        step();
        checks++;
        if (read_data !== 32'h0001_0003) begin
            failures++; $display("FAIL same_edge_old got=%h want=00010003", read_data);
        end
        config_read = 1'b1;
        config_addr = {8'd2, 24'd0};
        step();
        checks++;
        if (read_data !== 32'h0001_0001) begin
            failures++; $display("FAIL same_edge_new got=%h want=00010001", read_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            config_en   = ($urandom_range(0, 2) == 0);
            config_read = $urandom_range(0, 1) == 1;
            config_addr = {8'($urandom_range(0, 6)), 24'($urandom)};
            config_data = $urandom;
            step();
            for (int k = 0; k < NUM_OUT; k++) begin
                checks++;
                if (out_bus[k*WIDTH +: WIDTH] !== exp_out(k)) begin
                    failures++;
                    $display("FAIL rand_edge n=%0d out%0d got=%h want=%h", n, k, out_bus[k*WIDTH +: WIDTH], exp_out(k));
                end
            end
            checks++;
            if (read_data !== rd_m) begin
                failures++; $display("FAIL rand_read n=%0d got=%h want=%h", n, read_data, rd_m);
            end
            randomize_inputs();
            #1;
            for (int k = 0; k < NUM_OUT; k++) begin
                checks++;
                if (out_bus[k*WIDTH +: WIDTH] !== exp_out(k)) begin
                    failures++;
                    $display("FAIL rand_mid n=%0d out%0d got=%h want=%h", n, k, out_bus[k*WIDTH +: WIDTH], exp_out(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        config_en   = 1'b1;
        config_addr = {8'd1, 24'd0};
        config_data = 32'h0001_0104;
        set_track(4, 16'h1234);
        step();
        step();
        config_read = 1'b1;
        config_addr = {8'd1, 24'd0};
        step();
        checks++;
        if (out_bus[WIDTH +: WIDTH] !== 16'h1234 || read_data !== 32'h0001_0104) begin
            failures++;
            $display("FAIL async_setup out1=%h rd=%h want=1234/00010104", out_bus[WIDTH +: WIDTH], read_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_bus !== '0) begin
            failures++; $display("FAIL async_out got=%h want=0", out_bus);
        end
        checks++;
        if (read_data !== 32'd0) begin
            failures++; $display("FAIL async_rd got=%h want=0", read_data);
        end
        #2 reset = 1'b0;
        reset_model();
        config_read = 1'b1;
        config_addr = {8'd1, 24'd0};
        step();
        checks++;
        if (read_data !== 32'd0 || out_bus[WIDTH +: WIDTH] !== exp_out(1)) begin
            failures++;
            $display("FAIL async_after rd=%h out1=%h want=0/%h", read_data, out_bus[WIDTH +: WIDTH], exp_out(1));
        end
    endtask

    initial begin
        reset       = 1'b1;
        config_en   = 1'b0;
        config_read = 1'b0;
        config_addr = '0;
        config_data = '0;
        in_bus      = '0;
        reset_model();
        test_reset();
        test_comb();
        test_reg();
        test_oob();
        test_same_edge();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
